mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Sequential stage directly downstream of the 7x6 array multiplier.
- Consumes one 13-bit product per accepted beat and accumulates a frame of products into a wider saturating accumulator.
- Presents the frame sum with a valid/ready handshake.
- Mode input t selects signed (two's complement) or unsigned interpretation, matching the multiplier's t.

Parameters:
- PROD_W, 13, product width; equals the multiplier output width.
- ACC_W, 20, accumulator and result width; must be >= PROD_W+1.
- MAX_TERMS, 16, maximum beats per frame; the frame is force-closed at this count.
- CNT_W, 5, term counter width; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- t  in  1  1 = signed products, 0 = unsigned; sampled on the first beat of a frame only.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- product  in  PROD_W  product from the multiplier.
- in_last  in  1  final beat of the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  ACC_W  saturated frame sum.
- terms  out  CNT_W  number of beats accumulated into result.
- ovf  out  1  sticky: saturation occurred in this frame.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert handled externally):
  - state=IDLE; acc, result, terms, count = 0; ovf=0; out_valid=0; mode=0.
  - in_ready=1 from the first cycle after reset.
- Beat accepted when in_valid & in_ready.
- in_ready = (state != DONE), driven combinationally from the state register.
- States:
  - IDLE: on a beat, latch mode=t, acc=ext(product), count=1, ovf=0. Go to DONE if in_last or MAX_TERMS==1; otherwise go to ACCUM.
  - ACCUM: on a beat, acc=sat(acc+ext(product)), count+=1. Go to DONE if in_last or count+1==MAX_TERMS. With no beat, hold.
  - DONE: out_valid=1, result=acc, terms=count. On out_ready, clear out_valid and go to IDLE. acc is not cleared until the next first beat.
- Latency: out_valid rises the cycle after the closing beat is accepted. Result holds stable while out_valid & !out_ready.
- No input is accepted in DONE. A beat presented in the same cycle as the result handshake is accepted the following cycle, when state is IDLE.
- ext():
  - mode=1: sign-extend product[PROD_W-1] to ACC_W.
  - mode=0: zero-extend.
- sat():
  - Compute the sum at ACC_W+1 bits.
  - mode=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - mode=0: clamp to [0, 2^ACC_W-1].
  - On clamp, set ovf=1 for the rest of the frame. Once saturated, later opposite-sign terms still accumulate from the clamped value.
- A change of t mid-frame is ignored; mode is re-latched only on the first beat of the next frame.
- Frame of exactly MAX_TERMS beats with in_last on the last beat: closes once, identical to a forced close.
- in_last on a forced-close beat is consumed; no empty frame follows.
- Reset mid-frame or in DONE: result, flags and the pending frame are discarded immediately, and out_valid drops asynchronously.

Decomposition:
- Shared package mac_pkg holds:
  - State enum (IDLE, ACCUM, DONE).
  - Default widths PROD_W=13, ACC_W=20.
  - Function sat_add(acc, addend, mode) returning {ovf_bit, sum}.
- One natural sub-module, mac_sat_adder: combinational extend + add + clamp, reusable by later accumulation stages.
- The FSM and registers stay in mac_accumulator.

Test Plan:
- Unsigned, 4 beats of 13'h1F41 (127*63=8001), in_last on beat 4 -> cycle after beat 4: out_valid=1, result=32004, terms=4, ovf=0.
- Signed, beats 13'h1840 (-1984) and 13'h0800 (2048), in_last on beat 2 -> result=64, terms=2, ovf=0. Flip t to 0 on beat 2 -> same result.
- ACC_W=16, unsigned, 9 beats of 8001 -> result=65535, ovf=1, terms=9. ACC_W=14, signed, 5 beats of -1984 -> result=-8192, ovf=1.
- MAX_TERMS=16, 20 beats of product=1 with in_last never set -> first frame result=16, terms=16. in_ready=0 during DONE. Remaining 4 beats start a new frame.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0, no beat lost. Release -> next beat accepted the following cycle.
- Assert rst_n=0 mid-frame after 3 beats -> out_valid=0, result=0, ovf=0 immediately. A fresh single-beat frame of 5 after reset -> result=5, terms=1.

Source files
------------

// File: rtl/mac_pkg.sv
// ============================================================================
//  mac_pkg : shared types, default widths and saturating-add helper for the
//            accumulation stages behind the 7x6 array multiplier.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 13;
    localparam int ACC_W_DEF  = 20;

    // Working width of sat_add; callers extend into it, so ACC_W must stay below it.
    localparam int SAT_W = 32;

    localparam logic signed [SAT_W:0] SAT_ONE_S = (SAT_W+1)'(1);
    localparam logic        [SAT_W:0] SAT_ONE_U = (SAT_W+1)'(1);

    // Returns {ovf_bit, sum}; operands are already extended per mode.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] addend,
        input logic             mode,
        input int               acc_w
    );
        logic signed [SAT_W:0] s_sum;
        logic signed [SAT_W:0] s_hi;
        logic signed [SAT_W:0] s_lo;
        logic        [SAT_W:0] u_sum;
        logic        [SAT_W:0] u_hi;
        logic        [SAT_W:0] res;
        s_sum = $signed({acc[SAT_W-1], acc}) + $signed({addend[SAT_W-1], addend});
        s_hi  = (SAT_ONE_S <<< (acc_w - 1)) - SAT_ONE_S;
        s_lo  = -(SAT_ONE_S <<< (acc_w - 1));
        u_sum = {1'b0, acc} + {1'b0, addend};
        u_hi  = (SAT_ONE_U << acc_w) - SAT_ONE_U;
        if (mode) begin
            if (s_sum > s_hi)      res = {1'b1, s_hi[SAT_W-1:0]};
            else if (s_sum < s_lo) res = {1'b1, s_lo[SAT_W-1:0]};
            else                   res = {1'b0, s_sum[SAT_W-1:0]};
        end else if (u_sum > u_hi) begin
            res = {1'b1, u_hi[SAT_W-1:0]};
        end else begin
            res = {1'b0, u_sum[SAT_W-1:0]};
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_accumulator_if.sv
// ============================================================================
//  mac_accumulator_if : product-in / frame-sum-out handshake bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mac_accumulator_if #(
    parameter int PROD_W = 13,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 5
);
    logic              t;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  result;
    logic [CNT_W-1:0]  terms;
    logic              ovf;

    modport master (
        output t, in_valid, product, in_last, out_ready,
        input  in_ready, out_valid, result, terms, ovf
    );

    modport slave (
        input  t, in_valid, product, in_last, out_ready,
        output in_ready, out_valid, result, terms, ovf
    );
endinterface

`default_nettype wire

// File: rtl/mac_sat_adder.sv
// ============================================================================
//  mac_sat_adder : extend a product per mode, add to the accumulator, clamp.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mac_sat_adder
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_product,
    input  logic              i_mode,
    output logic [ACC_W-1:0]  o_ext,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);
    logic [SAT_W-1:0] w_acc_x;
    logic [SAT_W-1:0] w_prod_x;
    logic [SAT_W:0]   w_res;

    assign w_acc_x  = i_mode ? {{(SAT_W-ACC_W){i_acc[ACC_W-1]}}, i_acc}
                             : {{(SAT_W-ACC_W){1'b0}}, i_acc};
    assign w_prod_x = i_mode ? {{(SAT_W-PROD_W){i_product[PROD_W-1]}}, i_product}
                             : {{(SAT_W-PROD_W){1'b0}}, i_product};

    assign o_ext = w_prod_x[ACC_W-1:0];
    assign w_res = sat_add(w_acc_x, w_prod_x, i_mode, ACC_W);
    assign o_sum = w_res[ACC_W-1:0];
    assign o_ovf = w_res[SAT_W];

    // Bits above ACC_W are only the extension of the clamped sum.
    generate
        if (ACC_W < SAT_W) begin : g_hi_unused
            logic [SAT_W-ACC_W-1:0] w_unused_hi;
            assign w_unused_hi = w_res[SAT_W-1:ACC_W];
        end
    endgenerate
endmodule

`default_nettype wire

// File: rtl/mac_accumulator.sv
// ============================================================================
//  mac_accumulator : accumulates a frame of multiplier products into a
//                    saturating sum and presents it with valid/ready.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mac_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] C_MAX_TERMS = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_in_ready;
    logic             w_beat;
    logic             w_add_mode;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_sat;

    assign w_in_ready  = (r_state != ST_DONE);
    assign w_beat      = bus.in_valid & w_in_ready;
    // The first beat of a frame is extended with the live t, later beats with the latched mode.
    assign w_add_mode  = (r_state == ST_IDLE) ? bus.t : r_mode;
    assign w_count_inc = r_count + C_ONE;

    mac_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_adder (
        .i_acc     (r_acc),
        .i_product (bus.product),
        .i_mode    (w_add_mode),
        .o_ext     (w_ext),
        .o_sum     (w_sum),
        .o_ovf     (w_sat)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    w_mode_nxt  = bus.t;
                    w_acc_nxt   = w_ext;
                    w_count_nxt = C_ONE;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (bus.in_last || (MAX_TERMS == 1)) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_beat) begin
                    w_acc_nxt   = w_sum;
                    w_count_nxt = w_count_inc;
                    w_ovf_nxt   = r_ovf | w_sat;
                    w_state_nxt = (bus.in_last || (w_count_inc == C_MAX_TERMS)) ? ST_DONE
                                                                                : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_mode  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_mode  <= w_mode_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_acc;
    assign bus.terms     = r_count;
    assign bus.ovf       = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
//  tb_mac_accumulator : three accumulator widths driven in lockstep and
//                       compared against a frame-level arithmetic model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mac_accumulator;
    import mac_pkg::*;

    localparam int MAX_TERMS = 16;
    localparam int NI        = 3;
    localparam int W [NI]    = '{20, 16, 14};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_t     = 1'b0;
    logic        tb_valid = 1'b0;
    logic [12:0] tb_prod  = '0;
    logic        tb_last  = 1'b0;
    logic        tb_ordy  = 1'b0;

    always #5 clk = ~clk;

    mac_accumulator_if #(.PROD_W(13), .ACC_W(20), .CNT_W(5)) if20 ();
    mac_accumulator_if #(.PROD_W(13), .ACC_W(16), .CNT_W(5)) if16 ();
    mac_accumulator_if #(.PROD_W(13), .ACC_W(14), .CNT_W(5)) if14 ();

    assign if20.t = tb_t;  assign if20.in_valid = tb_valid;  assign if20.product = tb_prod;
    assign if20.in_last = tb_last;  assign if20.out_ready = tb_ordy;
    assign if16.t = tb_t;  assign if16.in_valid = tb_valid;  assign if16.product = tb_prod;
    assign if16.in_last = tb_last;  assign if16.out_ready = tb_ordy;
    assign if14.t = tb_t;  assign if14.in_valid = tb_valid;  assign if14.product = tb_prod;
    assign if14.in_last = tb_last;  assign if14.out_ready = tb_ordy;

    mac_accumulator #(.PROD_W(13), .ACC_W(20), .MAX_TERMS(MAX_TERMS), .CNT_W(5)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .bus(if20));
    mac_accumulator #(.PROD_W(13), .ACC_W(16), .MAX_TERMS(MAX_TERMS), .CNT_W(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16));
    mac_accumulator #(.PROD_W(13), .ACC_W(14), .MAX_TERMS(MAX_TERMS), .CNT_W(5)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .bus(if14));

    logic [63:0] o_res   [NI];
    logic [4:0]  o_terms [NI];
    logic        o_rdy   [NI];
    logic        o_vld   [NI];
    logic        o_ovf   [NI];

    assign o_res[0] = 64'(if20.result);  assign o_terms[0] = if20.terms;
    assign o_rdy[0] = if20.in_ready;     assign o_vld[0] = if20.out_valid;  assign o_ovf[0] = if20.ovf;
    assign o_res[1] = 64'(if16.result);  assign o_terms[1] = if16.terms;
    assign o_rdy[1] = if16.in_ready;     assign o_vld[1] = if16.out_valid;  assign o_ovf[1] = if16.ovf;
    assign o_res[2] = 64'(if14.result);  assign o_terms[2] = if14.terms;
    assign o_rdy[2] = if14.in_ready;     assign o_vld[2] = if14.out_valid;  assign o_ovf[2] = if14.ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: an open frame is a list of products; a closed frame awaits pickup.
    bit          m_done = 1'b0;
    bit          m_mode = 1'b0;
    logic [12:0] m_q [$];
    longint      e_val [NI];
    bit          e_ovf [NI];
    int          e_terms = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint model_sum(input int w, input bit mode, input logic [12:0] q [$],
                                         output bit ovf);
        longint acc = 0;
        longint lo;
        longint hi;
        longint v;
        ovf = 1'b0;
        if (mode) begin
            lo = -(64'sd1 <<< (w - 1));
            hi = (64'sd1 <<< (w - 1)) - 1;
        end else begin
            lo = 0;
            hi = (64'sd1 <<< w) - 1;
        end
        for (int i = 0; i < q.size(); i++) begin
            v = mode ? longint'($signed(q[i])) : longint'(q[i]);
            acc = (i == 0) ? v : acc + v;
            if (acc > hi) begin
                acc = hi;
                ovf = 1'b1;
            end else if (acc < lo) begin
                acc = lo;
                ovf = 1'b1;
            end
        end
        return acc;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("in_ready_w%0d", W[i]), 64'(o_rdy[i]), 64'(!m_done));
            chk($sformatf("out_valid_w%0d", W[i]), 64'(o_vld[i]), 64'(m_done));
            if (m_done) begin
                chk($sformatf("result_w%0d", W[i]), o_res[i],
                    64'(e_val[i]) & ((64'd1 << W[i]) - 64'd1));
                chk($sformatf("terms_w%0d", W[i]), 64'(o_terms[i]), 64'(e_terms));
                chk($sformatf("ovf_w%0d", W[i]), 64'(o_ovf[i]), 64'(e_ovf[i]));
            end
        end
    endtask

    task automatic model_update();
        if (m_done) begin
            if (tb_ordy) m_done = 1'b0;
        end else if (tb_valid) begin
            if (m_q.size() == 0) m_mode = tb_t;
            m_q.push_back(tb_prod);
            if (tb_last || m_q.size() == MAX_TERMS) begin
                for (int i = 0; i < NI; i++) e_val[i] = model_sum(W[i], m_mode, m_q, e_ovf[i]);
                e_terms = m_q.size();
                m_q.delete();
                m_done = 1'b1;
            end
        end
    endtask

    // One clock: check settled outputs, drive the next inputs, advance the model.
    task automatic step(input bit v, input logic [12:0] p, input bit l, input bit tt, input bit ordy);
        check_outputs();
        tb_valid = v;
        tb_prod  = p;
        tb_last  = l;
        tb_t     = tt;
        tb_ordy  = ordy;
        model_update();
        @(negedge clk);
    endtask

    task automatic drain();
        step(1'b0, 13'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        tb_valid = 1'b0;
        tb_last  = 1'b0;
        tb_ordy  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_out_valid_w%0d", tag, W[i]), 64'(o_vld[i]), 64'd0);
            chk($sformatf("%s_result_w%0d", tag, W[i]), o_res[i], 64'd0);
            chk($sformatf("%s_terms_w%0d", tag, W[i]), 64'(o_terms[i]), 64'd0);
            chk($sformatf("%s_ovf_w%0d", tag, W[i]), 64'(o_ovf[i]), 64'd0);
        end
        m_done = 1'b0;
        m_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_result_w%0d", W[i]), o_res[i], 64'd0);
            chk($sformatf("rst_terms_w%0d", W[i]), 64'(o_terms[i]), 64'd0);
            chk($sformatf("rst_ovf_w%0d", W[i]), 64'(o_ovf[i]), 64'd0);
        end

        // Unsigned 4 x 8001
        for (int k = 0; k < 4; k++) step(1'b1, 13'h1F41, (k == 3), 1'b0, 1'b0);
        chk("tp_unsigned_4x8001", o_res[0], 64'd32004);
        chk("tp_unsigned_4x8001_vld", 64'(o_vld[0]), 64'd1);
        drain();

        // Signed -1984 + 2048 with t dropped on the second beat
        step(1'b1, 13'h1840, 1'b0, 1'b1, 1'b0);
        step(1'b1, 13'h0800, 1'b1, 1'b0, 1'b0);
        chk("tp_signed_pair", o_res[0], 64'd64);
        drain();

        // Unsigned 9 x 8001 saturates the 16-bit instance
        for (int k = 0; k < 9; k++) step(1'b1, 13'h1F41, (k == 8), 1'b0, 1'b0);
        chk("tp_sat_u16_res", o_res[1], 64'd65535);
        chk("tp_sat_u16_ovf", 64'(o_ovf[1]), 64'd1);
        chk("tp_sat_u16_terms", 64'(o_terms[1]), 64'd9);
        drain();

        // Signed 5 x -1984 saturates the 14-bit instance low
        for (int k = 0; k < 5; k++) step(1'b1, 13'h1840, (k == 4), 1'b1, 1'b0);
        chk("tp_sat_s14_res", o_res[2], 64'h2000);
        chk("tp_sat_s14_ovf", 64'(o_ovf[2]), 64'd1);
        drain();

        // Forced close at MAX_TERMS, then a held result with a beat waiting
        for (int k = 0; k < 16; k++) step(1'b1, 13'd1, 1'b0, 1'b0, 1'b0);
        chk("tp_forced_res", o_res[0], 64'd16);
        chk("tp_forced_terms", 64'(o_terms[0]), 64'd16);
        for (int k = 0; k < 5; k++) step(1'b1, 13'd1, 1'b0, 1'b0, 1'b0);
        chk("tp_hold_in_ready", 64'(o_rdy[0]), 64'd0);
        step(1'b1, 13'd1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 13'd1, (k == 3), 1'b0, 1'b0);
        chk("tp_next_frame_res", o_res[0], 64'd4);
        chk("tp_next_frame_terms", 64'(o_terms[0]), 64'd4);
        drain();

        // Exactly MAX_TERMS beats with in_last on the final one
        for (int k = 0; k < 16; k++) step(1'b1, 13'd2, (k == 15), 1'b1, 1'b0);
        drain();
        step(1'b0, 13'd0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), 13'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) < 3));
        end
        drain();

        do_reset("rst_after_random");
        for (int k = 0; k < 3; k++) step(1'b1, 13'($urandom), 1'b0, 1'b1, 1'b0);
        do_reset("rst_mid_frame");
        step(1'b1, 13'd5, 1'b1, 1'b0, 1'b0);
        chk("tp_fresh_res", o_res[0], 64'd5);
        chk("tp_fresh_terms", 64'(o_terms[0]), 64'd1);
        drain();
        step(1'b1, 13'd7, 1'b1, 1'b1, 1'b0);
        do_reset("rst_in_done");
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
